// File: rtl/shift_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl_pkg
// Brief    : Shared types for the shift_reg_ctrl sequencing controller.
//            The PAR state is always present in the enum so every build sees
//            the same encoding; it is only reachable when
//            SHIFT_REG_CTRL_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_PAR   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl
// Brief    : Sequencing controller for the parallel-load shift register.
//            Accepts a word on a valid/ready handshake, loads it into the
//            external register, streams the register MSB out with
//            backpressure, then pulses frame_done.
//            Optional feature macro: SHIFT_REG_CTRL_PARITY_EN appends an
//            even-parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sr_load_en,
    output logic [WIDTH-1:0] sr_load_val,
    output logic             sr_shift_en,
    input  logic [WIDTH-1:0] sr_op,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_in_ready;
    logic               r_load_en;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic               r_parity;
`endif

    // Only the MSB of the register is observed; the rest is intentionally ignored.
    logic w_unused_sr_op;
    assign w_unused_sr_op = ^sr_op[WIDTH-2:0];

    // Frame sequencer: state, bit counter, captured word and registered strobes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_in_ready <= 1'b0;
            r_load_en  <= 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_load_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                        r_parity   <= ^in_data;
`endif
                        r_in_ready <= 1'b0;
                        r_load_en  <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt   <= '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                            r_state <= S_PAR;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef SHIFT_REG_CTRL_PARITY_EN
                S_PAR: begin
                    if (ser_ready) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Serial bit selection decoded from state; the register MSB during data bits.
    always_comb begin
        ser_out = 1'b0;
        case (r_state)
            S_SHIFT: ser_out = sr_op[WIDTH-1];
`ifdef SHIFT_REG_CTRL_PARITY_EN
            S_PAR:   ser_out = r_parity;
`endif
            default: ser_out = 1'b0;
        endcase
    end

    assign in_ready    = r_in_ready;
    assign sr_load_en  = r_load_en;
    assign sr_load_val = r_data;
    assign sr_shift_en = (r_state == S_SHIFT) && ser_ready;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    assign ser_valid   = (r_state == S_SHIFT) || (r_state == S_PAR);
`else
    assign ser_valid   = (r_state == S_SHIFT);
`endif
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_DONE);

endmodule
`default_nettype wire
